// File: rtl/mul_unit.sv
// mul_unit: sequential radix-2 shift-add multiplier for the RV64M multiply
// group (MUL, MULH, MULHSU, MULHU). Signed operands are reduced to their
// magnitudes on entry and the unsigned 128-bit product is negated at the
// end when exactly one operand was negative. Latency is a fixed 66 cycles
// from the accepting edge to the done pulse. There is no early-out for
// zero operands.

module mul_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // Mode encodings as seen on the mode input
  localparam logic [1:0] MODE_MUL    = 2'b00;
  localparam logic [1:0] MODE_MULH   = 2'b01;
  localparam logic [1:0] MODE_MULHSU = 2'b10;

  // Counter value seen during the final CALC cycle
  localparam logic [6:0] LAST_STEP = 7'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  // Operation latched at the accepting edge
  logic [1:0]         mode_q;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;

  // Running product and step counter
  logic [2*WIDTH-1:0] acc;
  logic [6:0]         count;

  // Combinational helpers
  logic               sa_in;
  logic               sb_in;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_fixed;
  logic               accept;

  // A request is only taken while idle; anything arriving while busy is dropped
  assign accept = (state == IDLE) && start;

  // Sign flags and operand magnitudes derived from the raw inputs
  always_comb begin
    sa_in = 1'b0;
    sb_in = 1'b0;
    if ((mode == MODE_MULH) || (mode == MODE_MULHSU)) begin
      sa_in = op_a[WIDTH-1];
    end
    if (mode == MODE_MULH) begin
      sb_in = op_b[WIDTH-1];
    end
    mag_a = sa_in ? -op_a : op_a;
    mag_b = sb_in ? -op_b : op_b;
  end

  // One shift-add step, plus the final sign correction of the full product
  always_comb begin
    addend    = mplier[0] ? mcand : '0;
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_fixed = (sa ^ sb) ? -acc : acc;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE -> CALC (64 steps) -> FIX -> DONE -> IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = CALC;
        end
      end
      CALC: begin
        if (count == LAST_STEP) begin
          next_state = FIX;
        end
      end
      FIX: begin
        next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Status outputs decoded purely from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      CALC, FIX: begin
        busy = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Operand capture, shift-add iteration and result load
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_MUL;
      sa     <= 1'b0;
      sb     <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q <= mode;
            sa     <= sa_in;
            sb     <= sb_in;
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            count  <= '0;
          end
        end
        CALC: begin
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + 7'd1;
        end
        FIX: begin
          acc <= acc_fixed;
          if (mode_q == MODE_MUL) begin
            result <= acc_fixed[WIDTH-1:0];
          end else begin
            result <= acc_fixed[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed and randomized checks of mul_unit against a
// reference product computed with plain 128-bit arithmetic on
// sign/zero-extended operands.

module tb_mul_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int test_count = 0;
  int fail_count = 0;

  mul_unit #(.WIDTH(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result of an RV64M multiply
  function automatic logic [63:0] refMul(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ax;
    logic [127:0] bx;
    logic [127:0] p;
    ax = ((m == 2'b01) || (m == 2'b10)) ? {{64{a[63]}}, a} : {64'd0, a};
    bx = (m == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ax * bx;
    return (m == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one operation from the next negedge (cycle 0) through last_cyc and
  // gathers timing observations; optionally pokes start with new operands
  task automatic applyStimulus(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b,
                               input int last_cyc, input int poke_cyc,
                               input logic [63:0] poke_a, input logic [63:0] poke_b,
                               output int done_cyc, output int done_cnt, output int busy_err,
                               output logic [63:0] res_done, output int hold_err);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    op_a  = a;
    op_b  = b;
    done_cyc = -1;
    done_cnt = 0;
    busy_err = 0;
    hold_err = 0;
    res_done = '0;
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      @(negedge clk);
      if (busy !== ((cyc >= 1) && (cyc <= 66))) busy_err++;
      if (done !== 1'b0) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          res_done = result;
        end
      end
      if ((done_cyc >= 0) && (cyc > done_cyc) && (result !== res_done)) hold_err++;
      if (cyc == 1) begin
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        mode  = ~m;
      end
      if (cyc == poke_cyc) begin
        start = 1'b1;
        op_a  = poke_a;
        op_b  = poke_b;
      end
      if (cyc == poke_cyc + 1) start = 1'b0;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] m, input logic [63:0] a, input logic [63:0] b,
                       input int last_cyc, input int poke_cyc,
                       input logic [63:0] poke_a, input logic [63:0] poke_b);
    int          done_cyc;
    int          done_cnt;
    int          busy_err;
    int          hold_err;
    logic [63:0] res_done;
    applyStimulus(m, a, b, last_cyc, poke_cyc, poke_a, poke_b,
                  done_cyc, done_cnt, busy_err, res_done, hold_err);
    checkOutput($sformatf("%s.done_cycle", tag), 64'(done_cyc), 64'd66);
    checkOutput($sformatf("%s.done_count", tag), 64'(done_cnt), 64'd1);
    checkOutput($sformatf("%s.busy_window", tag), 64'(busy_err), 64'd0);
    checkOutput($sformatf("%s.result", tag), res_done, refMul(m, a, b));
    checkOutput($sformatf("%s.result_hold", tag), 64'(hold_err), 64'd0);
  endtask

  initial begin
    int          rst_err;
    int          rst_done;
    logic        busy30;
    int          d1;
    int          d2;
    int          dcnt;
    logic [63:0] r1;
    logic [63:0] r2;
    logic        busy_end;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [1:0]  rm;

    // Reset state
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    checkOutput("reset.result", result, 64'd0);
    rst = 1'b0;

    // Directed operations
    runOp("mul_3x5", 2'b00, 64'd3, 64'd5, 80, -1, 64'd0, 64'd0);
    runOp("mulh_m1xm1", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 70, -1, 64'd0, 64'd0);
    runOp("mul_m1xm1", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 70, -1, 64'd0, 64'd0);
    runOp("mulhu_m1xm1", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 70, -1, 64'd0, 64'd0);
    runOp("mulhsu_m1x2", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 70, -1, 64'd0, 64'd0);
    runOp("mulh_minxmin", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 70, -1, 64'd0, 64'd0);
    runOp("mulhsu_minx3", 2'b10, 64'h8000_0000_0000_0000, 64'd3, 70, -1, 64'd0, 64'd0);
    runOp("mul_zero", 2'b00, 64'd0, 64'h1234_5678_9ABC_DEF0, 70, -1, 64'd0, 64'd0);

    // Start while busy is ignored
    runOp("busy_ignore", 2'b00, 64'd7, 64'd6, 80, 20, 64'd2, 64'd2);

    // Reset mid-operation, coinciding with a start request
    @(negedge clk);
    start    = 1'b1;
    mode     = 2'b00;
    op_a     = 64'd9;
    op_b     = 64'd9;
    rst_err  = 0;
    rst_done = 0;
    busy30   = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (cyc == 30) busy30 = busy;
      if ((cyc >= 31) && ((busy !== 1'b0) || (done !== 1'b0) || (result !== 64'd0))) rst_err++;
      if (done !== 1'b0) rst_done++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 30) begin
        rst   = 1'b1;
        start = 1'b1;
        op_a  = 64'd5;
      end
      if (cyc == 31) begin
        rst   = 1'b0;
        start = 1'b0;
      end
    end
    checkOutput("reset_mid.busy_before", 64'(busy30), 64'd1);
    checkOutput("reset_mid.outputs_cleared", 64'(rst_err), 64'd0);
    checkOutput("reset_mid.no_done", 64'(rst_done), 64'd0);
    runOp("after_reset_4x4", 2'b00, 64'd4, 64'd4, 70, -1, 64'd0, 64'd0);

    // Back-to-back with start held high
    @(negedge clk);
    start    = 1'b1;
    mode     = 2'b00;
    op_a     = 64'd2;
    op_b     = 64'd3;
    d1       = -1;
    d2       = -1;
    dcnt     = 0;
    r1       = '0;
    r2       = '0;
    busy_end = 1'b1;
    for (int cyc = 1; cyc <= 140; cyc++) begin
      @(negedge clk);
      if (done !== 1'b0) begin
        dcnt++;
        if (d1 < 0) begin
          d1 = cyc;
          r1 = result;
        end else if (d2 < 0) begin
          d2 = cyc;
          r2 = result;
        end
      end
      if (cyc == 1) begin
        op_a = 64'd5;
        op_b = 64'd5;
      end
      if (cyc == 133) start = 1'b0;
      if (cyc == 140) busy_end = busy;
    end
    checkOutput("b2b.first_done_cycle", 64'(d1), 64'd66);
    checkOutput("b2b.first_result", r1, refMul(2'b00, 64'd2, 64'd3));
    checkOutput("b2b.second_done_cycle", 64'(d2), 64'd133);
    checkOutput("b2b.second_result", r2, refMul(2'b00, 64'd5, 64'd5));
    checkOutput("b2b.done_count", 64'(dcnt), 64'd2);
    checkOutput("b2b.idle_after", 64'(busy_end), 64'd0);

    // Randomized operations
    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rm = 2'($urandom_range(3, 0));
      if (i == 0) ra = 64'h8000_0000_0000_0000;
      if (i == 1) rb = 64'h8000_0000_0000_0000;
      runOp($sformatf("random%0d_m%0d", i, rm), rm, ra, rb, 70, -1, 64'd0, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
# mul_unit

Sequential 64-bit multiplier for the RV64M multiply instructions (MUL, MULH, MULHSU, MULHU) in the multicycle datapath. It sits between operand registers A/B and the write-back mux. It takes both operands when `start` is pulsed by the control unit, iterates radix-2 shift-add for 64 cycles, and returns the selected 64-bit half of the 128-bit product with a one-cycle `done` pulse. Control holds its FSM in a wait state until `done`, then selects `result` for register write-back.

## Interface
- `WIDTH`, 64: operand width. Only 64 is supported. The counter is 7 bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `start`  in  1  request. Sampled only in IDLE.
- `mode`  in  2  operation, sampled with `start`: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `op_a`  in  64  rs1 value, sampled with `start`.
- `op_b`  in  64  rs2 value, sampled with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  64  selected product half. Held until the next accepted `start` or reset.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE**
  - If `start=1`, latch the mode and the sign flags:
    - sa = `op_a[63]` for modes 01 and 10, else 0.
    - sb = `op_b[63]` for mode 01 only, else 0.
  - Latch the magnitudes: mcand = sa ? −op_a : op_a, and mplier = sb ? −op_b : op_b. Both are 64-bit unsigned; 0x8000_0000_0000_0000 stays as is.
  - Clear the 128-bit accumulator and the counter, then go to CALC.
- **CALC** (one multiplier bit per cycle):
  - If `mplier[0]`, add mcand into accumulator bits [127:64] with carry out.
  - Shift the accumulator right by 1 with the carry entering bit 127.
  - Shift `mplier` right by 1 and increment the counter.
  - After 64 CALC cycles, go to FIX.
- **FIX**
  - If sa XOR sb, replace the accumulator with its 128-bit two's complement.
  - Load `result` with acc[63:0] for mode 00, or acc[127:64] otherwise.
  - Go to DONE.
- **DONE**
  - `done=1` for exactly this cycle, then go to IDLE.
- **Operands:** zero operands take no early-out; latency is fixed.
- **`start` while busy:** ignored. The in-flight operation completes unaffected, and no request is queued.
- **`start` held high in DONE:** not accepted until IDLE is reached, so a back-to-back accept happens one cycle after `done`.
- **Input stability:** `op_a`, `op_b` and `mode` may change freely after the sampling edge.

## Timing
- **Reset values:** state = IDLE, `busy=0`, `done=0`, `result=0`. The accumulator, counter and latched operands are also cleared.
- **Reset mid-operation:** `rst` high at any edge aborts to IDLE with all outputs at reset values; no `done` is produced. If `rst` and `start` are both high at the same edge, `rst` wins.
- **Latency:**
  - `start` sampled at the end of cycle 0.
  - CALC in cycles 1–64, FIX in cycle 65, DONE in cycle 66.
  - `done` is high in cycle 66 only; `result` is valid from cycle 66 onward.
  - `busy` is high in cycles 1–66 and low in cycle 67.
- **Throughput:** one operation per 67 cycles, with `start` high in the cycle after `done`.
- **Output timing:** `result` changes only at the FIX→DONE edge and at reset. `done` and `busy` are registered/state-decoded, with no combinational path from inputs.

## Test plan
- **MUL:** `op_a`=3, `op_b`=5, `mode`=00, `start` in cycle 0 → `busy` 1–66, `done` only in cycle 66, `result`=15. `result` holds at 15 through cycle 80.
- **Signed:** `op_a`=`op_b`=0xFFFF_FFFF_FFFF_FFFF.
  - `mode`=01 → `result`=0.
  - `mode`=00 → `result`=1.
  - `mode`=11 → `result`=0xFFFF_FFFF_FFFF_FFFE.
- **MULHSU:** `op_a`=0xFFFF_FFFF_FFFF_FFFF (−1), `op_b`=2 → `result`=0xFFFF_FFFF_FFFF_FFFF. Also `op_a`=0x8000_0000_0000_0000, `op_b`=0x8000_0000_0000_0000, `mode`=01 → `result`=0x4000_0000_0000_0000.
- **Busy ignore:** start 7×6 (MUL), then pulse `start` with 2×2 in cycle 20 and change the operands → `done` in cycle 66 only, `result`=42, and no second `done`.
- **Reset mid-op:** start 9×9, assert `rst` in cycle 30 → from cycle 31 `busy=0`, `done=0`, `result=0`, with no `done` ever. A fresh 4×4 started afterwards gives `result`=16 after 66 cycles.
- **Back-to-back:** hold `start=1` continuously with 2×3 then 5×5 → `done` in cycle 66 with 6, then `done` in cycle 133 with 25.
